// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared FSM states, MDU FIFO entry layout and the x0 register index
package rf_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_e;
    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/mdu_result_fifo.sv
// mdu_result_fifo: MDU result FIFO with per-entry live bits and rd-match squash
//   push_i/push_rd_i/push_data_i : enqueue at tail (rd==x0 enqueues a dead entry)
//   pop_i                        : drop head
//   sq_en_i/sq_rd_i              : kill every live entry whose rd matches
//   head_o, empty_o, full_o, count_o : head entry and occupancy status
//   sq_cnt_o                     : number of entries killed by this cycle's squash
module mdu_result_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [4:0]    push_rd_i,
    input  logic [31:0]   push_data_i,
    input  logic          pop_i,
    input  logic          sq_en_i,
    input  logic [4:0]    sq_rd_i,
    output entry_t        head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] sq_cnt_o
);
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    // Unoccupied slots always have live=0, so the squash only touches buffered results.
    // The push is applied last so a same-cycle push with the squashed rd survives.
    always_comb begin
        sq_cnt_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (sq_en_i && mem_q[i].live && mem_q[i].rd == sq_rd_i) begin
                mem_d[i].live = 1'b0;
                sq_cnt_o      = sq_cnt_o + CW'(1);
            end
            if (pop_i && PW'(i) == rd_q) mem_d[i].live = 1'b0;
            if (push_i && PW'(i) == wr_q)
                mem_d[i] = '{live: push_rd_i != REG_ZERO, rd: push_rd_i, data: push_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_q + PW'(push_i);
            rd_q  <= rd_q + PW'(pop_i);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign count_o = cnt_q;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the RF write port between pipeline writeback and buffered MDU results
//   wb_rf_wb/wb_rd/wb_data    : pipeline write request (priority, x0 ignored)
//   mdu_valid/mdu_rd/mdu_data : MDU result, accepted when mdu_ready (= !full)
//   stall_wb                  : high in the single forced-drain cycle
//   rf_we/rf_waddr/rf_wdata   : registered RF write port
//   RF_ARB_PERF_CNT_EN adds perf_stall_cnt and perf_squash_cnt
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_rf_wb,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        stall_wb,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
`ifdef RF_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_squash_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(MAX_WAIT + 1);

    state_e        state_q, state_d;
    logic [AW-1:0] age_q, age_d;
    entry_t        head;
    logic          empty, full;
    logic [CW-1:0] cnt, cnt_nxt, sq_cnt;
    logic          eff_wb, head_live, grant_wb, grant_mdu, push, pop, force_go;

    assign eff_wb    = wb_rf_wb && wb_rd != REG_ZERO;
    assign head_live = !empty && head.live;
    assign grant_wb  = state_q != FORCE && eff_wb;
    assign grant_mdu = head_live && !grant_wb;
    // A dead head leaves without the port, even while the pipeline owns it.
    assign pop       = !empty && (grant_mdu || !head.live);
    assign push      = mdu_valid && !full;
    assign cnt_nxt   = cnt + CW'(push) - CW'(pop);
    assign force_go  = head_live && !grant_mdu && (age_q == AW'(MAX_WAIT - 1) || (full && mdu_valid));
    assign mdu_ready = !full;
    assign stall_wb  = state_q == FORCE;

    mdu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_rd_i   (mdu_rd),
        .push_data_i (mdu_data),
        .pop_i       (pop),
        .sq_en_i     (grant_wb),
        .sq_rd_i     (wb_rd),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full),
        .count_o     (cnt),
        .sq_cnt_o    (sq_cnt)
    );

    // force_go is only reachable from PEND (IDLE has no head, FORCE always grants it).
    always_comb begin
        state_d = force_go ? FORCE : (cnt_nxt == '0 ? IDLE : PEND);
        age_d   = (empty || pop) ? '0
                : (head_live && !grant_mdu && age_q != AW'(MAX_WAIT)) ? age_q + AW'(1) : age_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            age_q    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
            rf_we   <= grant_wb || grant_mdu;
            if (grant_wb || grant_mdu) begin
                rf_waddr <= grant_wb ? wb_rd : head.rd;
                rf_wdata <= grant_wb ? wb_data : head.data;
            end
        end
    end

`ifdef RF_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_squash_cnt <= '0;
        end else begin
            perf_stall_cnt  <= perf_stall_cnt + 32'(stall_wb);
            perf_squash_cnt <= perf_squash_cnt + 32'(sq_cnt);
        end
    end
`else
    logic unused_sq;
    assign unused_sq = ^sq_cnt;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: table-driven directed bench for rf_write_arbiter (DEPTH=2, MAX_WAIT=8)
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_rf_wb = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready, stall_wb, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef RF_ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_squash_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(2), .MAX_WAIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_rf_wb  (wb_rf_wb),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .mdu_valid (mdu_valid),
        .mdu_rd    (mdu_rd),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .stall_wb  (stall_wb),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
`ifdef RF_ARB_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_squash_cnt (perf_squash_cnt)
`endif
    );

    // Inputs for one cycle and the outputs expected just after that cycle's edge.
    typedef struct {
        logic        wb;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic wb, input logic [4:0] wrd, input logic [31:0] wdat,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic st, input logic rdy);
        return '{wb, wrd, wdat, mv, mrd, mdat, we, wa, wd, st, rdy};
    endfunction

    function automatic vec_t idle0();
        return v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic [4:0] wrd, input logic [31:0] wdat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        @(negedge clk);
        wb_rf_wb  = wb;
        wb_rd     = wrd;
        wb_data   = wdat;
        mdu_valid = mv;
        mdu_rd    = mrd;
        mdu_data  = mdat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // pipeline write to x5
        tbl.push_back(v(1, 5, 32'hA5, 0, 0, 0, 1, 5, 32'hA5, 0, 1));
        tbl.push_back(idle0());
        // lone MDU result drains on the next free cycle
        tbl.push_back(v(0, 0, 0, 1, 3, 32'h11, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 3, 32'h11, 0, 1));
        tbl.push_back(idle0());
        // age-limited forced drain under continuous pipeline traffic
        tbl.push_back(v(1, 9, 32'h90, 1, 7, 32'h77, 1, 9, 32'h90, 0, 1));
        for (int k = 0; k < 8; k++)
            tbl.push_back(v(1, 9, 32'h100 + 32'(k), 0, 0, 0, 1, 9, 32'h100 + 32'(k), k == 7, 1));
        tbl.push_back(v(1, 9, 32'h1FF, 0, 0, 0, 1, 7, 32'h77, 0, 1));
        tbl.push_back(v(1, 9, 32'h1FF, 0, 0, 0, 1, 9, 32'h1FF, 0, 1));
        // WAW squash: younger pipeline write kills buffered rd=4
        tbl.push_back(v(0, 0, 0, 1, 4, 32'h22, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 4, 32'h33, 0, 0, 0, 1, 4, 32'h33, 0, 1));
        tbl.push_back(idle0());
        tbl.push_back(idle0());
        // full FIFO with a third result waiting forces a drain
        tbl.push_back(v(1, 10, 32'hA0, 1, 11, 32'hB1, 1, 10, 32'hA0, 0, 1));
        tbl.push_back(v(1, 10, 32'hA1, 1, 12, 32'hC2, 1, 10, 32'hA1, 0, 0));
        tbl.push_back(v(1, 10, 32'hA2, 1, 13, 32'hD3, 1, 10, 32'hA2, 1, 0));
        tbl.push_back(v(1, 10, 32'hA3, 1, 13, 32'hD3, 1, 11, 32'hB1, 0, 1));
        tbl.push_back(v(1, 10, 32'hA3, 1, 13, 32'hD3, 1, 10, 32'hA3, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 12, 32'hC2, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 13, 32'hD3, 0, 1));
        tbl.push_back(idle0());
        // x0 on both sides never reaches the RF
        tbl.push_back(v(1, 0, 32'hFF, 1, 0, 32'hEE, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 0, 32'hFF, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(idle0());
        // head squashed on the FORCE entry edge: FORCE pops it without writing
        tbl.push_back(v(0, 0, 0, 1, 7, 32'h70, 0, 0, 0, 0, 1));
        for (int k = 0; k < 7; k++)
            tbl.push_back(v(1, 9, 32'h200 + 32'(k), 0, 0, 0, 1, 9, 32'h200 + 32'(k), 0, 1));
        tbl.push_back(v(1, 7, 32'h2F0, 0, 0, 0, 1, 7, 32'h2F0, 1, 1));
        tbl.push_back(v(1, 7, 32'h2F1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 7, 32'h2F1, 0, 0, 0, 1, 7, 32'h2F1, 0, 1));
        tbl.push_back(idle0());

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_we", rf_we, 0);
        chk("reset rf_waddr", rf_waddr, 0);
        chk("reset rf_wdata", rf_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset stall_wb", stall_wb, 0);
        chk("post-reset mdu_ready", mdu_ready, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].wb, tbl[i].wrd, tbl[i].wdat, tbl[i].mv, tbl[i].mrd, tbl[i].mdat);
            chk($sformatf("row%0d rf_we", i), rf_we, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("row%0d rf_waddr", i), rf_waddr, tbl[i].wa);
                chk($sformatf("row%0d rf_wdata", i), rf_wdata, tbl[i].wd);
            end
            chk($sformatf("row%0d stall_wb", i), stall_wb, tbl[i].st);
            chk($sformatf("row%0d mdu_ready", i), mdu_ready, tbl[i].rdy);
        end

`ifdef RF_ARB_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, 3);
        chk("perf_squash_cnt", perf_squash_cnt, 2);
`endif

        // reset mid-operation discards a buffered result
        drive(1, 9, 32'h300, 1, 20, 32'h55);
        @(negedge clk);
        rst_n = 1'b0;
        wb_rf_wb = 1'b0;
        mdu_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset rf_we", rf_we, 0);
        chk("midreset rf_waddr", rf_waddr, 0);
        chk("midreset rf_wdata", rf_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset mdu_ready", mdu_ready, 1);
        chk("midreset stall_wb", stall_wb, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("midreset discarded", rf_we, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("midreset still idle", rf_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
